// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON round scheduler.
// Holds the sequencer state encoding, block-type codes and round indices.
// Imported by the scheduler and its round counter.
package ascon_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        WAIT_BLK = 3'd2,
        PERM     = 3'd3,
        FINAL    = 3'd4,
        DONE     = 3'd5
    } state_e;

    // Host block type as carried on in_type_i
    localparam logic BLK_AD = 1'b0;
    localparam logic BLK_PT = 1'b1;

    // Round indices: p12 runs 0..11, p8 runs 4..11
    localparam int P12_FIRST  = 0;
    localparam int P8_FIRST   = 4;
    localparam int LAST_ROUND = 11;

endpackage

// File: rtl/ascon_round_counter.sv
// Round counter for the ASCON permutation FSM; also flags the last active round.
// Latency: loads/increments visible one cycle later; perm_done_o is combinational.
// No backpressure: follows the FSM init/active strobes every cycle.
module ascon_round_counter #(
    parameter int P12_FIRST  = ascon_pkg::P12_FIRST,
    parameter int P8_FIRST   = ascon_pkg::P8_FIRST,
    parameter int LAST_ROUND = ascon_pkg::LAST_ROUND
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       init_p12_i,
    input  logic       init_p8_i,
    input  logic       active_i,
    output logic [3:0] round_o,
    output logic       perm_done_o
);

    localparam logic [3:0] P12_R  = 4'(P12_FIRST);
    localparam logic [3:0] P8_R   = 4'(P8_FIRST);
    localparam logic [3:0] LAST_R = 4'(LAST_ROUND);

    logic [3:0] round_q;
    logic [3:0] round_d;

    // Next round: p12 load has priority over p8 load, then saturating increment
    always_comb begin
        round_d = round_q;
        if (init_p12_i) begin
            round_d = P12_R;
        end else if (init_p8_i) begin
            round_d = P8_R;
        end else if (active_i && (round_q != LAST_R)) begin
            round_d = round_q + 4'd1;
        end
    end

    // Round register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            round_q <= 4'd0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round_o     = round_q;
    assign perm_done_o = active_i && (round_q == LAST_R);

endmodule

// File: rtl/ascon_round_scheduler.sv
// Sequences the ASCON permutation FSM from a host AD/PT block stream.
// Latency: start/data_valid pulses one cycle after the triggering event; done one cycle after last perm_done.
// Backpressure: in_ready_o is high only in WAIT_BLK; blocks offered elsewhere wait for it.
module ascon_round_scheduler #(
    parameter int DATA_W     = 64,
    parameter int P12_FIRST  = ascon_pkg::P12_FIRST,
    parameter int P8_FIRST   = ascon_pkg::P8_FIRST,
    parameter int LAST_ROUND = ascon_pkg::LAST_ROUND,
    parameter int CNT_W      = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cmd_start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_type_i,
    input  logic              in_last_i,
    input  logic              init_round_p12_i,
    input  logic              init_round_p8_i,
    input  logic              active_round_i,
    output logic [3:0]        round_o,
    output logic              start_o,
    output logic              data_valid_o,
    output logic [DATA_W-1:0] block_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [CNT_W-1:0]  block_cnt_o
);

    import ascon_pkg::*;

    logic perm_done;

    ascon_round_counter #(
        .P12_FIRST  (P12_FIRST),
        .P8_FIRST   (P8_FIRST),
        .LAST_ROUND (LAST_ROUND)
    ) u_round_counter (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .init_p12_i  (init_round_p12_i),
        .init_p8_i   (init_round_p8_i),
        .active_i    (active_round_i),
        .round_o     (round_o),
        .perm_done_o (perm_done)
    );

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic              dv_q, dv_d;
    logic [DATA_W-1:0] block_q, block_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              seen_pt_q, seen_pt_d;   // a PT block was accepted in this operation
    logic              last_pt_q, last_pt_d;   // the block in flight is the final PT block

    // Sequencer next-state, pulse generation and block bookkeeping
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        dv_d      = 1'b0;
        block_d   = block_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        seen_pt_d = seen_pt_q;
        last_pt_d = last_pt_q;
        case (state_q)
            IDLE: begin
                if (cmd_start_i) begin
                    start_d   = 1'b1;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    seen_pt_d = 1'b0;
                    last_pt_d = 1'b0;
                    state_d   = INIT;
                end
            end
            INIT: begin
                if (perm_done) begin
                    state_d = WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                if (in_valid_i) begin
                    if ((in_type_i == BLK_AD) && seen_pt_q) begin
                        // AD after PT is out of order: drop it and abort
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        block_d   = in_data_i;
                        cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                        dv_d      = 1'b1;
                        // in_last_i only marks the end of the message on PT blocks
                        last_pt_d = (in_type_i == BLK_PT) && in_last_i;
                        if (in_type_i == BLK_PT) begin
                            seen_pt_d = 1'b1;
                        end
                        state_d = PERM;
                    end
                end
            end
            PERM: begin
                if (perm_done) begin
                    if (last_pt_q) begin
                        dv_d    = 1'b1;
                        state_d = FINAL;
                    end else begin
                        state_d = WAIT_BLK;
                    end
                end
            end
            FINAL: begin
                if (perm_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, pulse and block registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            dv_q      <= 1'b0;
            block_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            seen_pt_q <= 1'b0;
            last_pt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            dv_q      <= dv_d;
            block_q   <= block_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            seen_pt_q <= seen_pt_d;
            last_pt_q <= last_pt_d;
        end
    end

    assign in_ready_o   = (state_q == WAIT_BLK);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign start_o      = start_q;
    assign data_valid_o = dv_q;
    assign block_o      = block_q;
    assign block_cnt_o  = cnt_q;
    assign error_o      = err_q;

endmodule

// File: tb/tb_ascon_round_scheduler.sv
// Directed bench for ascon_round_scheduler.
module tb_ascon_round_scheduler;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] in_data_i = '0;
    logic        in_type_i = 1'b0;
    logic        in_last_i = 1'b0;
    logic        init_round_p12_i = 1'b0;
    logic        init_round_p8_i = 1'b0;
    logic        active_round_i = 1'b0;
    logic [3:0]  round_o;
    logic        start_o;
    logic        data_valid_o;
    logic [63:0] block_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [7:0]  block_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [63:0] AD_A5 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] PT_11 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] PT_22 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] AD_33 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] AD_44 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] AD_55 = 64'h5555_5555_5555_5555;

    ascon_round_scheduler dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .cmd_start_i      (cmd_start_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_data_i        (in_data_i),
        .in_type_i        (in_type_i),
        .in_last_i        (in_last_i),
        .init_round_p12_i (init_round_p12_i),
        .init_round_p8_i  (init_round_p8_i),
        .active_round_i   (active_round_i),
        .round_o          (round_o),
        .start_o          (start_o),
        .data_valid_o     (data_valid_o),
        .block_o          (block_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .block_cnt_o      (block_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Run one permutation on the FSM side: load strobe, then active rounds up to 11
    task automatic run_perm(input bit use_p12, input string tag);
        int first;
        first = use_p12 ? 0 : 4;
        if (use_p12) init_round_p12_i = 1'b1;
        else         init_round_p8_i  = 1'b1;
        tick();
        init_round_p12_i = 1'b0;
        init_round_p8_i  = 1'b0;
        active_round_i   = 1'b1;
        for (int r = first; r <= 11; r++) begin
            n_vec++; if (round_o !== 4'(r)) begin n_err++; $display("FAIL %s_round: got %0d want %0d", tag, round_o, r); end
            tick();
        end
        active_round_i = 1'b0;
    endtask

    // Offer one block in WAIT_BLK and confirm it is taken
    task automatic send_block(input logic [63:0] dat, input logic typ, input logic last, input string tag);
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL %s_ready: got %0b want 1", tag, in_ready_o); end
        in_valid_i = 1'b1; in_data_i = dat; in_type_i = typ; in_last_i = last;
        tick();
        in_valid_i = 1'b0; in_last_i = 1'b0;
        n_vec++; if (data_valid_o !== 1'b1) begin n_err++; $display("FAIL %s_dv: got %0b want 1", tag, data_valid_o); end
        n_vec++; if (block_o !== dat) begin n_err++; $display("FAIL %s_block: got %h want %h", tag, block_o, dat); end
        n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL %s_ready_off: got %0b want 0", tag, in_ready_o); end
    endtask

    task automatic start_op(input string tag);
        cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0;
        n_vec++; if (start_o !== 1'b1) begin n_err++; $display("FAIL %s_start: got %0b want 1", tag, start_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL %s_busy: got %0b want 1", tag, busy_o); end
        n_vec++; if (error_o !== 1'b0) begin n_err++; $display("FAIL %s_err_clr: got %0b want 0", tag, error_o); end
        n_vec++; if (block_cnt_o !== 8'd0) begin n_err++; $display("FAIL %s_cnt_clr: got %0d want 0", tag, block_cnt_o); end
        tick();
        n_vec++; if (start_o !== 1'b0) begin n_err++; $display("FAIL %s_start_once: got %0b want 0", tag, start_o); end
    endtask

    task automatic test_reset_state();
        tick();
        n_vec++; if ({round_o, start_o, data_valid_o, busy_o, done_o, error_o, in_ready_o} !== 10'd0) begin n_err++; $display("FAIL reset_ctl: got %b want 0", {round_o, start_o, data_valid_o, busy_o, done_o, error_o, in_ready_o}); end
        n_vec++; if ({block_o, block_cnt_o} !== 72'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", {block_o, block_cnt_o}); end
        reset_i = 1'b0;
        tick();
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_idle: got %0b want 0", busy_o); end
    endtask

    task automatic test_p12_init();
        start_op("p12");
        init_round_p12_i = 1'b1;
        tick();
        init_round_p12_i = 1'b0;
        active_round_i   = 1'b1;
        for (int r = 0; r <= 11; r++) begin
            n_vec++; if (round_o !== 4'(r)) begin n_err++; $display("FAIL p12_count: got %0d want %0d", round_o, r); end
            n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL p12_ready_init: got %0b want 0", in_ready_o); end
            tick();
        end
        // still active: round holds at 11, perm_done in WAIT_BLK is ignored
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL p12_wait_blk: got %0b want 1", in_ready_o); end
        tick();
        active_round_i = 1'b0;
        n_vec++; if (round_o !== 4'd11) begin n_err++; $display("FAIL p12_saturate: got %0d want 11", round_o); end
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL p12_ignore_done: got %0b want 1", in_ready_o); end
    endtask

    task automatic test_ad_pt_message();
        send_block(AD_A5, 1'b0, 1'b1, "ad");   // last on AD means nothing
        n_vec++; if (block_cnt_o !== 8'd1) begin n_err++; $display("FAIL ad_cnt: got %0d want 1", block_cnt_o); end
        tick();
        n_vec++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL ad_dv_once: got %0b want 0", data_valid_o); end
        run_perm(1'b0, "ad_p8");
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL ad_back_wait: got %0b want 1", in_ready_o); end
        n_vec++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL ad_no_final_dv: got %0b want 0", data_valid_o); end
        send_block(PT_11, 1'b1, 1'b1, "pt");
        n_vec++; if (block_cnt_o !== 8'd2) begin n_err++; $display("FAIL pt_cnt: got %0d want 2", block_cnt_o); end
        run_perm(1'b0, "pt_p8");
        n_vec++; if (data_valid_o !== 1'b1) begin n_err++; $display("FAIL final_dv: got %0b want 1", data_valid_o); end
        n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL final_ready: got %0b want 0", in_ready_o); end
        tick();
        n_vec++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL final_dv_once: got %0b want 0", data_valid_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL done_early: got %0b want 0", done_o); end
        run_perm(1'b1, "final_p12");
        n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL done_pulse: got %0b want 1", done_o); end
        tick();
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL done_once: got %0b want 0", done_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL done_idle: got %0b want 0", busy_o); end
        n_vec++; if (block_cnt_o !== 8'd2 || error_o !== 1'b0) begin n_err++; $display("FAIL done_cnt_err: got %0d/%0b want 2/0", block_cnt_o, error_o); end
    endtask

    task automatic test_ad_after_pt();
        start_op("seq");
        run_perm(1'b1, "seq_p12");
        send_block(PT_22, 1'b1, 1'b0, "seq_pt");
        run_perm(1'b0, "seq_p8");
        in_valid_i = 1'b1; in_data_i = AD_33; in_type_i = 1'b0;
        tick();
        in_valid_i = 1'b0;
        n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL seq_error: got %0b want 1", error_o); end
        n_vec++; if (block_o !== PT_22) begin n_err++; $display("FAIL seq_block_kept: got %h want %h", block_o, PT_22); end
        n_vec++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL seq_no_dv: got %0b want 0", data_valid_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL seq_idle: got %0b want 0", busy_o); end
        n_vec++; if (block_cnt_o !== 8'd1) begin n_err++; $display("FAIL seq_cnt: got %0d want 1", block_cnt_o); end
        tick();
        n_vec++; if (error_o !== 1'b1) begin n_err++; $display("FAIL seq_sticky: got %0b want 1", error_o); end
    endtask

    task automatic test_valid_during_perm();
        start_op("bp");
        run_perm(1'b1, "bp_p12");
        send_block(AD_44, 1'b0, 1'b0, "bp_ad");
        in_valid_i = 1'b1; in_data_i = AD_55; in_type_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (in_ready_o !== 1'b0 || block_o !== AD_44) begin n_err++; $display("FAIL bp_hold: got rdy=%0b blk=%h want 0/%h", in_ready_o, block_o, AD_44); end
        end
        run_perm(1'b0, "bp_p8");
        n_vec++; if (in_ready_o !== 1'b1 || block_o !== AD_44) begin n_err++; $display("FAIL bp_wait: got rdy=%0b blk=%h want 1/%h", in_ready_o, block_o, AD_44); end
        tick();
        in_valid_i = 1'b0;
        n_vec++; if (block_o !== AD_55 || data_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_accept: got blk=%h dv=%0b want %h/1", block_o, data_valid_o, AD_55); end
        n_vec++; if (block_cnt_o !== 8'd2) begin n_err++; $display("FAIL bp_cnt: got %0d want 2", block_cnt_o); end
    endtask

    task automatic test_init_collision();
        cmd_start_i = 1'b1;
        tick();
        cmd_start_i = 1'b0;
        n_vec++; if (start_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL busy_start: got start=%0b busy=%0b want 0/1", start_o, busy_o); end
        init_round_p12_i = 1'b1; init_round_p8_i = 1'b1;
        tick();
        init_round_p12_i = 1'b0; init_round_p8_i = 1'b0;
        n_vec++; if (round_o !== 4'd0) begin n_err++; $display("FAIL init_both: got %0d want 0", round_o); end
    endtask

    task automatic test_reset_mid_perm();
        // scheduler is in PERM; bring the counter to 7
        init_round_p8_i = 1'b1;
        tick();
        init_round_p8_i = 1'b0;
        active_round_i  = 1'b1;
        repeat (3) tick();
        active_round_i = 1'b0;
        n_vec++; if (round_o !== 4'd7 || busy_o !== 1'b1) begin n_err++; $display("FAIL rst_setup: got round=%0d busy=%0b want 7/1", round_o, busy_o); end
        #2 reset_i = 1'b1;
        #1;
        n_vec++; if ({round_o, start_o, data_valid_o, busy_o, done_o, error_o, in_ready_o} !== 10'd0) begin n_err++; $display("FAIL rst_async_ctl: got %b want 0", {round_o, start_o, data_valid_o, busy_o, done_o, error_o, in_ready_o}); end
        n_vec++; if ({block_o, block_cnt_o} !== 72'd0) begin n_err++; $display("FAIL rst_async_data: got %h want 0", {block_o, block_cnt_o}); end
        #1 reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if ({start_o, data_valid_o, done_o, busy_o} !== 4'd0) begin n_err++; $display("FAIL rst_no_pulse: got %b want 0000", {start_o, data_valid_o, done_o, busy_o}); end
        end
    endtask

    initial begin
        test_reset_state();
        test_p12_init();
        test_ad_pt_message();
        test_ad_after_pt();
        test_valid_during_perm();
        test_init_collision();
        test_reset_mid_perm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
